uart_rx_param: RTL and testbench

Parametrised UART receiver: the next-generation RX block with configurable data width, parity mode, stop-bit count and oversampling ratio. It runs from an external oversample tick, recovers frames from the serial line, and presents each byte with per-frame parity and framing status. A valid/ready holding register decouples it from the consumer and flags overruns. It sits between the pad-side synchroniser and the RX FIFO or register interface.

---
 rtl/uart_rx_param_if.sv | 26 ++
 rtl/uart_rx_param.sv | 202 ++++++++++++++++++++
 tb/tb_uart_rx_param.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_param_if.sv
// Bus between the UART receiver and its line/consumer side.
// The receiver uses the slave modport; the line driver and consumer use master.
interface uart_rx_param_if #(
  parameter int DATA_BITS = 8
);
  logic                 rx;
  logic                 baud_tick;
  logic                 data_ready;
  logic [DATA_BITS-1:0] data_out;
  logic                 data_valid;
  logic                 parity_error;
  logic                 framing_error;
  logic                 overrun_error;
  logic                 busy;
  logic [2:0]           fsm_state;

  modport master (
    output rx, baud_tick, data_ready,
    input  data_out, data_valid, parity_error, framing_error, overrun_error, busy, fsm_state
  );

  modport slave (
    input  rx, baud_tick, data_ready,
    output data_out, data_valid, parity_error, framing_error, overrun_error, busy, fsm_state
  );
endinterface

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with a valid/ready holding register and overrun flag.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling around each sample point.
module uart_rx_param #(
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1,
  parameter int OVERSAMPLE  = 16
) (
  input  logic             CLK,
  input  logic             RST,
  uart_rx_param_if.slave   bus
);
  localparam int MAXB = (DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS;
  localparam int TW   = $clog2(OVERSAMPLE);
  localparam int BW   = $clog2(MAXB);

  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]           state_q, state_d;
  logic [TW-1:0]        tick_q, tick_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_err_q, par_err_d;
  logic                 frm_err_q, frm_err_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 pe_q, pe_d;
  logic                 fe_q, fe_d;
  logic                 ovr_q, ovr_d;

  logic                 sample_w;
  logic                 commit;
  logic                 frame_fe;
  logic                 hs;

`ifdef UART_RX_MAJORITY_EN
  // Holds rx from the two ticks preceding the current one.
  logic [1:0] hist_q, hist_d;

  assign hist_d   = {hist_q[0], bus.rx};
  assign sample_w = (hist_q[1] & hist_q[0]) | (hist_q[1] & bus.rx) | (hist_q[0] & bus.rx);

  always_ff @(posedge CLK) begin
    if (RST) begin
      hist_q <= 2'b11;
    end else if (bus.baud_tick) begin
      hist_q <= hist_d;
    end
  end
`else
  assign sample_w = bus.rx;
`endif

  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    par_err_d = par_err_q;
    frm_err_d = frm_err_q;
    commit    = 1'b0;
    frame_fe  = frm_err_q;

    if (bus.baud_tick) begin
      case (state_q)
        S_IDLE: begin
          if (!bus.rx) begin
            state_d = S_START;
            tick_d  = '0;
          end
        end
        S_START: begin
          if (tick_q == TICK_MID) begin
            if (sample_w) begin
              state_d = S_IDLE;
            end else begin
              state_d   = S_DATA;
              tick_d    = '0;
              bit_d     = '0;
              par_err_d = 1'b0;
              frm_err_d = 1'b0;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        S_DATA: begin
          if (tick_q == TICK_LAST) begin
            tick_d  = '0;
            shift_d = {sample_w, shift_q[DATA_BITS-1:1]};
            if (bit_q == DATA_LAST) begin
              bit_d   = '0;
              state_d = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        S_PARITY: begin
          if (tick_q == TICK_LAST) begin
            tick_d    = '0;
            par_err_d = (PARITY_MODE == 2) ? ~((^shift_q) ^ sample_w) : ((^shift_q) ^ sample_w);
            state_d   = S_STOP;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        S_STOP: begin
          if (tick_q == TICK_LAST) begin
            tick_d    = '0;
            frame_fe  = frm_err_q | ~sample_w;
            frm_err_d = frame_fe;
            if (bit_q == STOP_LAST) begin
              bit_d   = '0;
              commit  = 1'b1;
              state_d = S_IDLE;
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Handshake: a word transfers on any cycle with data_valid and data_ready both high.
  // A frame finishing in that same cycle refills the register; one finishing while the
  // register is full and not being taken is dropped and raises the sticky overrun flag.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    pe_d    = pe_q;
    fe_d    = fe_q;
    ovr_d   = ovr_q;
    hs      = valid_q & bus.data_ready;

    if (hs) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
    if (commit) begin
      if (!valid_q || hs) begin
        data_d  = shift_q;
        pe_d    = par_err_q;
        fe_d    = frame_fe;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      tick_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      par_err_q <= 1'b0;
      frm_err_q <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      pe_q      <= 1'b0;
      fe_q      <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      par_err_q <= par_err_d;
      frm_err_q <= frm_err_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      pe_q      <= pe_d;
      fe_q      <= fe_d;
      ovr_q     <= ovr_d;
    end
  end

  assign bus.data_out      = data_q;
  assign bus.data_valid    = valid_q;
  assign bus.parity_error  = pe_q;
  assign bus.framing_error = fe_q;
  assign bus.overrun_error = ovr_q;
  assign bus.busy          = (state_q != S_IDLE);
  assign bus.fsm_state     = state_q;
endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: channel A is 8N1 x16, channel B is 8 bits, even parity,
// two stop bits, x8. Frames are modelled as bit lists; results are scoreboarded.
module tb_uart_rx_param;
  localparam int OS_A = 16;
  localparam int OS_B = 8;

  logic clk = 1'b0;
  logic rst;
  logic tick;

  int n_vec = 0;
  int n_err = 0;

  logic [9:0] exp_q_a[$];
  logic [9:0] exp_q_b[$];

  int vcyc_a = 0;
  int busy_ticks_a = 0;

  uart_rx_param_if #(.DATA_BITS(8)) ifa ();
  uart_rx_param_if #(.DATA_BITS(8)) ifb ();

  assign ifa.baud_tick = tick;
  assign ifb.baud_tick = tick;

  uart_rx_param #(.DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1), .OVERSAMPLE(OS_A)) dut_a (
    .CLK(clk), .RST(rst), .bus(ifa.slave)
  );
  uart_rx_param #(.DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(2), .OVERSAMPLE(OS_B)) dut_b (
    .CLK(clk), .RST(rst), .bus(ifb.slave)
  );

  // ---------------- clock / reset / tick ----------------
  always #5 clk = ~clk;

  initial begin
    tick = 1'b0;
    forever begin
      repeat (3) @(posedge clk);
      #1 tick = 1'b1;
      @(posedge clk);
      #1 tick = 1'b0;
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout expected completion");
    n_err++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Frame result as the line protocol defines it: {framing, parity, data}.
  function automatic logic [9:0] model(input int ch, input logic [7:0] d, input logic pbit,
                                       input logic [1:0] st);
    logic pe;
    logic fe;
    if (ch == 0) begin
      pe = 1'b0;
      fe = (st[0] == 1'b0);
    end else begin
      pe = (($countones(d) + int'(pbit)) % 2) != 0;
      fe = (st[0] == 1'b0) || (st[1] == 1'b0);
    end
    return {fe, pe, d};
  endfunction

  // ---------------- monitors ----------------
  initial begin
    logic pv;
    logic phs;
    logic [9:0] e;
    pv  = 1'b0;
    phs = 1'b0;
    forever begin
      @(negedge clk);
      if (ifa.data_valid) vcyc_a++;
      if (tick && ifa.busy) busy_ticks_a++;
      if (ifa.data_valid && (!pv || phs)) begin
        if (exp_q_a.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL a_unexpected: got %0h expected no frame", ifa.data_out);
        end else begin
          e = exp_q_a.pop_front();
          check("a_frame", {22'd0, ifa.framing_error, ifa.parity_error, ifa.data_out}, {22'd0, e});
        end
      end
      pv  = ifa.data_valid;
      phs = ifa.data_valid && ifa.data_ready;
    end
  end

  initial begin
    logic pv;
    logic phs;
    logic [9:0] e;
    pv  = 1'b0;
    phs = 1'b0;
    forever begin
      @(negedge clk);
      if (ifb.data_valid && (!pv || phs)) begin
        if (exp_q_b.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL b_unexpected: got %0h expected no frame", ifb.data_out);
        end else begin
          e = exp_q_b.pop_front();
          check("b_frame", {22'd0, ifb.framing_error, ifb.parity_error, ifb.data_out}, {22'd0, e});
        end
      end
      pv  = ifb.data_valid;
      phs = ifb.data_valid && ifb.data_ready;
    end
  end

  // ---------------- drivers ----------------
  task automatic wait_tick();
    @(posedge clk);
    while (tick !== 1'b1) @(posedge clk);
  endtask

  task automatic set_rx(input int ch, input logic v);
    if (ch == 0) ifa.rx = v;
    else ifb.rx = v;
  endtask

  task automatic send_bits(input int ch, input logic b, input int nticks);
    #1 set_rx(ch, b);
    repeat (nticks) wait_tick();
  endtask

  task automatic send_frame(input int ch, input logic [7:0] d, input logic pbit,
                            input logic [1:0] st, input int abort_at, input bit expect_out);
    logic bits[$];
    int os;
    os = (ch == 0) ? OS_A : OS_B;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (ch == 1) bits.push_back(pbit);
    bits.push_back(st[0]);
    if (ch == 1) bits.push_back(st[1]);
    if (expect_out) begin
      if (ch == 0) exp_q_a.push_back(model(ch, d, pbit, st));
      else exp_q_b.push_back(model(ch, d, pbit, st));
    end
    for (int i = 0; i < bits.size(); i++) begin
      if (i == abort_at) begin
        #1 set_rx(ch, 1'b1);
        return;
      end
      send_bits(ch, bits[i], os);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_a_data"},  {24'd0, ifa.data_out}, 32'd0);
    check({tag, "_a_flags"}, {27'd0, ifa.data_valid, ifa.parity_error, ifa.framing_error,
                              ifa.overrun_error, ifa.busy}, 32'd0);
    check({tag, "_b_data"},  {24'd0, ifb.data_out}, 32'd0);
    check({tag, "_b_flags"}, {27'd0, ifb.data_valid, ifb.parity_error, ifb.framing_error,
                              ifb.overrun_error, ifb.busy}, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] d;
    logic [1:0] st;
    logic pbit;
    int ch;

    rst = 1'b1;
    ifa.rx = 1'b1;
    ifb.rx = 1'b1;
    ifa.data_ready = 1'b1;
    ifb.data_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) wait_tick();

    // 8N1 0xA5 with ready held: one-cycle valid pulse
    vcyc_a = 0;
    send_frame(0, 8'hA5, 1'b0, 2'b11, -1, 1'b1);
    send_bits(0, 1'b1, 4);
    check("a5_valid_cycles", vcyc_a, 1);

    // even parity: wrong parity bit then correct one
    send_frame(1, 8'h3C, 1'b1, 2'b11, -1, 1'b1);
    send_bits(1, 1'b1, 4);
    send_frame(1, 8'h3C, 1'b0, 2'b11, -1, 1'b1);
    send_bits(1, 1'b1, 4);

    // 4-tick glitch while idle: false start after 8 ticks of busy
    busy_ticks_a = 0;
    vcyc_a = 0;
    send_bits(0, 1'b0, 4);
    send_bits(0, 1'b1, 20);
    check("glitch_busy_ticks", busy_ticks_a, 8);
    check("glitch_no_valid", vcyc_a, 0);
    check("glitch_idle", {31'd0, ifa.busy}, 32'd0);

    // second and first stop bit low on the two-stop channel
    send_frame(1, 8'h81, 1'b0, 2'b01, -1, 1'b1);
    send_bits(1, 1'b1, 4);
    send_frame(1, 8'h81, 1'b0, 2'b10, -1, 1'b1);
    send_bits(1, 1'b1, 4);

    // overrun: second frame dropped while the first is held
    ifa.data_ready = 1'b0;
    send_frame(0, 8'h11, 1'b0, 2'b11, -1, 1'b1);
    send_bits(0, 1'b1, 4);
    send_frame(0, 8'h22, 1'b0, 2'b11, -1, 1'b0);
    send_bits(0, 1'b1, 4);
    @(negedge clk);
    check("ovr_data_held", {24'd0, ifa.data_out}, 32'h11);
    check("ovr_valid", {31'd0, ifa.data_valid}, 32'd1);
    check("ovr_flag", {31'd0, ifa.overrun_error}, 32'd1);
    @(posedge clk);
    #1 ifa.data_ready = 1'b1;
    @(posedge clk);
    #1 ifa.data_ready = 1'b0;
    @(negedge clk);
    check("ovr_after_hs_valid", {31'd0, ifa.data_valid}, 32'd0);
    check("ovr_after_hs_flag", {31'd0, ifa.overrun_error}, 32'd0);

    // reset in the middle of DATA with a word held, then a clean frame
    send_frame(0, 8'h33, 1'b0, 2'b11, -1, 1'b1);
    send_bits(0, 1'b1, 4);
    send_frame(0, 8'hC7, 1'b0, 2'b11, 4, 1'b0);
    check("pre_rst_busy", {31'd0, ifa.busy}, 32'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("midrst");
    @(posedge clk);
    #1 rst = 1'b0;
    ifa.data_ready = 1'b1;
    repeat (2) wait_tick();
    send_frame(0, 8'h5A, 1'b0, 2'b11, -1, 1'b1);
    send_bits(0, 1'b1, 4);

    // randomized frames on both channels
    for (int n = 0; n < 24; n++) begin
      ch = $urandom_range(0, 1);
      d = 8'($urandom);
      pbit = (^d) ^ ($urandom_range(0, 3) == 0);
      st = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
      send_frame(ch, d, pbit, st, -1, 1'b1);
      send_bits(ch, 1'b1, $urandom_range(1, 12));
    end

    repeat (8) wait_tick();
    check("a_queue_drained", exp_q_a.size(), 0);
    check("b_queue_drained", exp_q_b.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
